gated_acc_tx: RTL and testbench

//  Transmit side of the split-clock 15-bit accumulator register. Accumulates

---
 rtl/gated_acc_tx.sv | 154 +++++++++++++++
 tb/tb_gated_acc_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gated_acc_tx.sv
`default_nettype none
// ============================================================================
//  Module      : gated_acc_tx
//  Description : Transmit side of a split-clock accumulator register. Sums
//                binary-MLP XNOR/popcount beats into a signed DW-bit neuron
//                value, offers it on a valid/ready port and pulses hi_en when
//                the upper field [DW-1:LO_W] changes, so the receiver's gated
//                half is clocked only then.
//                Optional build macro: GATED_ACC_SAT_EN (saturating adds;
//                otherwise the sum wraps modulo 2^DW).
//  Revision    : 1.0 - initial release
// ============================================================================
module gated_acc_tx #(
  parameter int IN_W  = 16,
  parameter int BEATS = 8,
  parameter int DW    = 15,
  parameter int LO_W  = 7
) (
  input  logic            gated_clk,
  input  logic            rst7,
  input  logic            start,
  input  logic [DW-1:0]   bias,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] xnor_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   dout,
  output logic            hi_en,
  output logic            busy
);

  localparam int PW = $clog2(IN_W + 1);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HW = DW - LO_W;

  localparam logic [CW-1:0]      c_last_beat = CW'(BEATS - 1);
  localparam logic signed [DW:0] c_in_w      = (DW + 1)'(IN_W);
  localparam logic [DW-1:0]      c_max_pos   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]      c_max_neg   = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                r_state;
  logic [DW-1:0]         r_acc;
  logic [CW-1:0]         r_beat_cnt;
  logic [DW-1:0]         r_dout;
  logic [HW-1:0]         r_last_hi;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_hi_en;
  logic                  r_busy;

  logic [PW-1:0]         w_pop;
  logic signed [DW:0]    w_term;
  logic signed [DW:0]    w_sum;
  logic [DW-1:0]         w_next_acc;
  logic                  w_ovf;

  // Population count of the XNOR bits for the current beat
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < IN_W; i++) begin
      w_pop = w_pop + PW'(xnor_bits[i]);
    end
  end

  // Beat term (2*popcount - IN_W) and the DW+1-bit signed sum with overflow handling
  always_comb begin
    w_term = $signed({{(DW-PW){1'b0}}, w_pop, 1'b0}) - c_in_w;
    w_sum  = $signed({r_acc[DW-1], r_acc}) + w_term;
    w_ovf  = w_sum[DW] ^ w_sum[DW-1];
`ifdef GATED_ACC_SAT_EN
    if (w_ovf) begin
      w_next_acc = w_sum[DW] ? c_max_neg : c_max_pos;
    end else begin
      w_next_acc = w_sum[DW-1:0];
    end
`else
    // Wrap: the top guard bit is simply dropped
    w_next_acc = w_sum[DW-1:0];
`endif
  end

  // Control FSM with registered handshake outputs and the hi-field change detector
  always_ff @(posedge gated_clk or negedge rst7) begin
    if (!rst7) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_dout      <= '0;
      r_last_hi   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_hi_en     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // hi_en is a single-cycle pulse; only the final-beat edge raises it
      r_hi_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ACC;
            r_acc      <= bias;
            r_beat_cnt <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            r_acc <= w_next_acc;
            if (r_beat_cnt == c_last_beat) begin
              r_state     <= S_SEND;
              r_beat_cnt  <= '0;
              r_dout      <= w_next_acc;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_hi_en     <= (w_next_acc[DW-1:LO_W] != r_last_hi);
              r_last_hi   <= w_next_acc[DW-1:LO_W];
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign hi_en     = r_hi_en;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gated_acc_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gated_acc_tx
//  Description : Self-checking bench for gated_acc_tx. Directed cases plus
//                randomized sums compared against an arithmetic model of the
//                neuron sum and the hi-field change flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gated_acc_tx;

  logic        gated_clk = 1'b0;
  logic        rst7      = 1'b0;
  logic        start     = 1'b0;
  logic [14:0] bias      = '0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] xnor_bits = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] dout;
  logic        hi_en;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int m_last_hi = 0;

  gated_acc_tx dut (
    .gated_clk (gated_clk),
    .rst7      (rst7),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xnor_bits (xnor_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .hi_en     (hi_en),
    .busy      (busy)
  );

  always #5 gated_clk = ~gated_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one beat adds 2*ones(x)-16 to the running signed value
  function automatic int m_add(input int acc, input logic [15:0] x);
    int s;
    s = acc + 2 * $countones(x) - 16;
`ifdef GATED_ACC_SAT_EN
    if (s > 16383)  s = 16383;
    if (s < -16384) s = -16384;
`else
    s = ((s % 32768) + 32768) % 32768;
    if (s >= 16384) s = s - 32768;
`endif
    return s;
  endfunction

  // One full transaction; entered and left on a falling edge with the DUT idle
  task automatic run_sum(input logic [14:0] b, input logic [15:0] xs[8],
                         input int bub_mode, input int hold, input bit pre_ready,
                         input bit start_in_accept, input string tag);
    int          s;
    int          cyc;
    int          exp_hi;
    bit          exp_hen;
    logic [14:0] exp_d;
    logic [31:0] sv;
    s = int'($signed(b));
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    start     = 1'b1;
    bias      = b;
    out_ready = pre_ready;
    @(negedge gated_clk);
    start = 1'b0;
    chk({tag, "_acc_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_acc_busy"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && (bub_mode == 1 || (bub_mode == 2 && $urandom_range(0, 2) == 0))) begin
        in_valid  = 1'b0;
        xnor_bits = 16'($urandom);
        @(negedge gated_clk);
        cyc++;
      end
      in_valid  = 1'b1;
      xnor_bits = xs[i];
      s = m_add(s, xs[i]);
      @(negedge gated_clk);
      cyc++;
    end
    in_valid = 1'b0;
    sv       = 32'(s);
    exp_d    = sv[14:0];
    exp_hi   = int'(exp_d[14:7]);
    exp_hen  = (exp_hi != m_last_hi);
    m_last_hi = exp_hi;
    chk({tag, "_dout"}, {17'b0, dout}, {17'b0, exp_d});
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_hi_en"}, {31'b0, hi_en}, {31'b0, exp_hen});
    chk({tag, "_send_in_ready"}, {31'b0, in_ready}, 32'd0);
    if (bub_mode == 1) chk({tag, "_cycles"}, 32'(cyc), 32'd15);
    if (pre_ready) begin
      start = start_in_accept;
      @(negedge gated_clk);
    end else begin
      for (int h = 0; h < hold; h++) begin
        start = 1'($urandom_range(0, 1));
        @(negedge gated_clk);
        chk({tag, "_hold_dout"}, {17'b0, dout}, {17'b0, exp_d});
        chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_hold_hi_en"}, {31'b0, hi_en}, 32'd0);
        chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      start     = start_in_accept;
      out_ready = 1'b1;
      @(negedge gated_clk);
    end
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_done_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done_hi_en"}, {31'b0, hi_en}, 32'd0);
    chk({tag, "_done_in_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  initial begin
    logic [15:0] xs[8];

    // Reset state
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_hi_en", {31'b0, hi_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dout", {17'b0, dout}, 32'd0);
    @(negedge gated_clk);
    rst7 = 1'b1;
    @(negedge gated_clk);

    // Case 2: all-ones beats from zero bias
    for (int i = 0; i < 8; i++) xs[i] = 16'hFFFF;
    run_sum(15'd0, xs, 0, 0, 1'b0, 1'b0, "sum_ones");
    chk("sum_ones_const", {17'b0, dout}, 32'd128);

    // Case 3: alternating beats, then the same sum again (no hi change)
    for (int i = 0; i < 8; i++) xs[i] = (i % 2 == 0) ? 16'h0000 : 16'h00FF;
    run_sum(15'd5, xs, 0, 0, 1'b0, 1'b0, "sum_alt");
    chk("sum_alt_const", {17'b0, dout}, 32'h7FC5);
    // Case 4: same sum held under backpressure with start toggling
    run_sum(15'd5, xs, 0, 10, 1'b0, 1'b0, "bp");

    // Case 5: bubbles every other cycle
    for (int i = 0; i < 8; i++) xs[i] = 16'hFFFF;
    run_sum(15'd0, xs, 1, 0, 1'b0, 1'b0, "bubble");
    chk("bubble_const", {17'b0, dout}, 32'd128);

    // Ready high before valid, start raised in the accept cycle
    run_sum(15'd0, xs, 0, 0, 1'b1, 1'b1, "preready");
    @(negedge gated_clk);
    chk("accept_start_ignored", {31'b0, busy}, 32'd0);

    // Case 6: positive and negative overflow
    xs[0] = 16'hFFFF;
    for (int i = 1; i < 8; i++) xs[i] = 16'h00FF;
    run_sum(15'd16383, xs, 0, 1, 1'b0, 1'b0, "ovf_pos");
`ifdef GATED_ACC_SAT_EN
    chk("ovf_pos_const", {17'b0, dout}, 32'd16383);
`else
    chk("ovf_pos_const", {17'b0, dout}, 32'h400F);
`endif
    xs[0] = 16'h0000;
    run_sum(15'h4000, xs, 0, 1, 1'b0, 1'b0, "ovf_neg");
`ifdef GATED_ACC_SAT_EN
    chk("ovf_neg_const", {17'b0, dout}, 32'h4000);
`else
    chk("ovf_neg_const", {17'b0, dout}, 32'd16368);
`endif

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) xs[i] = 16'($urandom);
      run_sum(15'($urandom), xs, 2, $urandom_range(0, 4),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      @(negedge gated_clk);
    end

    // Case 1: reset asserted in the middle of accumulation
    start = 1'b1;
    bias  = 15'd100;
    @(negedge gated_clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      xnor_bits = 16'($urandom);
      @(negedge gated_clk);
    end
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst7 = 1'b0;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_hi_en", {31'b0, hi_en}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_dout", {17'b0, dout}, 32'd0);
    in_valid  = 1'b0;
    m_last_hi = 0;
    @(negedge gated_clk);
    rst7 = 1'b1;
    @(negedge gated_clk);
    chk("after_rst_busy", {31'b0, busy}, 32'd0);
    chk("after_rst_in_ready", {31'b0, in_ready}, 32'd0);

    // A fresh sum after reset sees last_hi cleared
    for (int i = 0; i < 8; i++) xs[i] = 16'hFFFF;
    run_sum(15'd0, xs, 0, 2, 1'b0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
